// File: rtl/my_div_pkg.sv
// my_div shared types and constants.
// State encodings and handshake levels for the iterative divider.
package my_div_pkg;

    localparam int DATA_W = 32;

    typedef enum logic [1:0] {
        DivFree   = 2'b00,
        DivByZero = 2'b01,
        DivOn     = 2'b10,
        DivEnd    = 2'b11
    } div_state_e;

    localparam logic DivStart          = 1'b1;
    localparam logic DivStop           = 1'b0;
    localparam logic DivResultReady    = 1'b1;
    localparam logic DivResultNotReady = 1'b0;

    localparam logic [DATA_W-1:0] ZeroWord = '0;

endpackage

// File: rtl/my_div_step.sv
// my_div_step: one combinational restoring-division step.
// Working value is {rem, dvd}; the quotient bit enters at the LSB.
module my_div_step #(
    parameter int W = 32
) (
    input  logic [2*W-1:0] work_i,
    input  logic [W-1:0]   divisor_i,
    output logic [2*W-1:0] work_o,
    output logic           qbit_o
);

    logic [W:0] trial;

    // Subtract divisor from {rem, next dividend bit}; restore on borrow.
    always_comb begin
        trial  = work_i[2*W-1:W-1] - {1'b0, divisor_i};
        qbit_o = ~trial[W];
        if (qbit_o) begin
            work_o = {trial[W-1:0], work_i[W-2:0], 1'b0};
        end else begin
            work_o = {work_i[2*W-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/my_div.sv
// my_div: iterative restoring 32-bit divider, signed/unsigned.
// Optional macro MY_DIV_ZERO_DIVIDEND_SHORTCUT_EN: zero dividend skips iterations.
module my_div
    import my_div_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                signed_div_i,
    input  logic [DATA_W-1:0]   opdata1_i,
    input  logic [DATA_W-1:0]   opdata2_i,
    input  logic                start_i,
    input  logic                annul_i,
    output logic [2*DATA_W-1:0] result_o,
    output logic                ready_o
);

    localparam int CNT_W = $clog2(DATA_W) + 1;

    div_state_e          state_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [2*DATA_W-1:0] work_q;
    logic [DATA_W-1:0]   dsr_q;
    logic                sign_q_q;
    logic                sign_r_q;

    logic                s1;
    logic                s2;
    logic                short_path;
    logic [DATA_W-1:0]   dvd_abs;
    logic [DATA_W-1:0]   dsr_abs;
    logic [2*DATA_W-1:0] step_work;
    logic                step_qbit;
    logic [2*DATA_W-1:0] step_d;
    logic [2*DATA_W-1:0] fix_d;

    my_div_step #(.W(DATA_W)) u_step (
        .work_i    (work_q),
        .divisor_i (dsr_q),
        .work_o    (step_work),
        .qbit_o    (step_qbit)
    );

    // Operand magnitudes, signs, next iteration value and sign fix-up.
    always_comb begin
        s1      = signed_div_i & opdata1_i[DATA_W-1];
        s2      = signed_div_i & opdata2_i[DATA_W-1];
        dvd_abs = s1 ? (~opdata1_i + 1'b1) : opdata1_i;
        dsr_abs = s2 ? (~opdata2_i + 1'b1) : opdata2_i;
`ifdef MY_DIV_ZERO_DIVIDEND_SHORTCUT_EN
        short_path = (opdata2_i == '0) || (opdata1_i == '0);
`else
        short_path = (opdata2_i == '0);
`endif
        step_d = step_work | {{(2*DATA_W-1){1'b0}}, step_qbit};
        fix_d[DATA_W-1:0] = sign_q_q ? (~work_q[DATA_W-1:0] + 1'b1)
                                     : work_q[DATA_W-1:0];
        fix_d[2*DATA_W-1:DATA_W] = sign_r_q
                                 ? (~work_q[2*DATA_W-1:DATA_W] + 1'b1)
                                 : work_q[2*DATA_W-1:DATA_W];
    end

    // Divider FSM with registered result and ready outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= DivFree;
            cnt_q    <= '0;
            work_q   <= '0;
            dsr_q    <= '0;
            sign_q_q <= 1'b0;
            sign_r_q <= 1'b0;
            result_o <= '0;
            ready_o  <= DivResultNotReady;
        end else begin
            unique case (state_q)
                DivFree: begin
                    ready_o  <= DivResultNotReady;
                    result_o <= '0;
                    if (start_i == DivStart && !annul_i) begin
                        if (short_path) begin
                            state_q <= DivByZero;
                        end else begin
                            state_q  <= DivOn;
                            cnt_q    <= '0;
                            work_q   <= {{DATA_W{1'b0}}, dvd_abs};
                            dsr_q    <= dsr_abs;
                            sign_q_q <= s1 ^ s2;
                            sign_r_q <= s1;
                        end
                    end
                end
                DivByZero: begin
                    work_q  <= '0;
                    state_q <= DivEnd;
                end
                DivOn: begin
                    if (annul_i) begin
                        state_q <= DivFree;
                        cnt_q   <= '0;
                    end else if (cnt_q != CNT_W'(DATA_W)) begin
                        work_q <= step_d;
                        cnt_q  <= cnt_q + 1'b1;
                    end else begin
                        work_q  <= fix_d;
                        state_q <= DivEnd;
                        cnt_q   <= '0;
                    end
                end
                DivEnd: begin
                    if (start_i == DivStop) begin
                        state_q  <= DivFree;
                        ready_o  <= DivResultNotReady;
                        result_o <= '0;
                    end else begin
                        ready_o  <= DivResultReady;
                        result_o <= work_q;
                    end
                end
                default: state_q <= DivFree;
            endcase
        end
    end

endmodule
